alu_muldiv_seq: RTL

Multi-cycle sequencer that implements the RV32M unsigned multiply/divide subset by iterating the existing 32-bit combinational `alu` (add op `4'b0000`, sub op `4'b0001`). Sits beside the execute stage: the pipeline issues one request through a valid/ready handshake, stalls, and collects the result through a second valid/ready handshake. One operation is in flight at a time.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/alu.sv | 22 ++
 rtl/alu_muldiv_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M unsigned multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULHU = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_REMU  = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam int ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu.sv
// Existing 32-bit combinational execute-stage alu; the sequencer only uses add and sub.
module alu (
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [3:0]  op_code,
    output logic [31:0] out
);

    always_comb begin
        out = '0;
        case (op_code)
            4'b0000: out = in_a + in_b;
            4'b0001: out = in_a - in_b;
            4'b0010: out = in_a & in_b;
            4'b0011: out = in_a | in_b;
            4'b0100: out = in_a ^ in_b;
            4'b0101: out = {31'd0, (in_a < in_b)};
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer: one op in flight, 32 alu
// iterations of shift-add (multiply) or restoring subtract (divide).
module alu_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err
);

    state_t state_q, state_d;

    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  b_q;
    // hi_q doubles as the remainder and lo_q as the quotient during divides.
    logic [XLEN-1:0]  hi_q, lo_q;
    logic [4:0]       cnt_q;
    logic [XLEN-1:0]  data_q;
    logic             err_q;

    logic             accept;
    logic             req_legal;
    logic             req_div0;
    logic             is_mul;
    logic             last_iter;

    logic [XLEN-1:0]  alu_a, alu_out;
    logic [3:0]       alu_op;
    logic [XLEN-1:0]  sum;
    logic             carry;
    logic [XLEN-1:0]  shl_rem;
    logic             ge;
    logic [XLEN-1:0]  hi_nx, lo_nx;
    logic [XLEN-1:0]  result_nx;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_data  = data_q;
    assign resp_tag   = tag_q;
    assign resp_err   = err_q;

    assign accept    = req_valid && req_ready && !flush;
    assign req_legal = op_is_mul(req_op) || op_is_div(req_op);
    assign req_div0  = op_is_div(req_op) && (req_b == '0);
    assign is_mul    = op_is_mul(op_q);
    assign last_iter = (cnt_q == 5'd31);

    // Divide step works on the 33-bit value {rem, quo[31]}; its top bit is hi_q[31].
    assign shl_rem = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    assign alu_a   = is_mul ? hi_q : shl_rem;
    assign alu_op  = is_mul ? ALU_ADD : ALU_SUB;

    alu alu (
        .in_a    (alu_a),
        .in_b    (b_q),
        .op_code (alu_op),
        .out     (alu_out)
    );

    always_comb begin
        sum   = lo_q[0] ? alu_out : hi_q;
        carry = lo_q[0] && (alu_out < hi_q);
        ge    = hi_q[XLEN-1] || (shl_rem >= b_q);
        if (is_mul) begin
            hi_nx = {carry, sum[XLEN-1:1]};
            lo_nx = {sum[0], lo_q[XLEN-1:1]};
        end else begin
            hi_nx = ge ? alu_out : shl_rem;
            lo_nx = {lo_q[XLEN-2:0], ge};
        end
        result_nx = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? lo_nx : hi_nx;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (req_legal && !req_div0) ? CALC : DONE;
            CALC: if (last_iter) state_d = DONE;
            DONE: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q   <= '0;
            tag_q  <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            op_q  <= req_op;
            tag_q <= req_tag;
            b_q   <= req_b;
            hi_q  <= '0;
            lo_q  <= req_a;
            cnt_q <= '0;
            err_q <= !req_legal;
            // Short-circuit results are final at acceptance; CALC overwrites otherwise.
            if (!req_legal)                 data_q <= '0;
            else if (req_div0)              data_q <= (req_op == OP_DIVU) ? '1 : req_a;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (state_q == CALC) begin
            hi_q  <= hi_nx;
            lo_q  <= lo_nx;
            cnt_q <= cnt_q + 5'd1;
            if (last_iter) data_q <= result_nx;
        end
    end

endmodule
